// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch PC, req/ack imem reads, prefetch FIFO to decode, redirect flush.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  input  logic        instr_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  state_t state, state_n;
  logic [31:0] fpc, stale;
  logic [31:0] mem_pc [FIFO_DEPTH];
  logic [31:0] mem_ins [FIFO_DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic push, pop, nonempty;
  always_comb begin
    nonempty = count != '0;
    imem_req = reset && (state == DISCARD || (state == FETCH && count != DEPTH));
    imem_addr = reset ? (state == DISCARD ? stale : fpc) : '0;
    instr_valid = nonempty && !redirect;
    instr = nonempty ? mem_ins[rd] : '0;
    instr_pc = nonempty ? mem_pc[rd] : '0;
    instr_pc4 = nonempty ? mem_pc[rd] + 32'd4 : '0;
    push = state == FETCH && imem_req && imem_ack && !redirect;
    pop = instr_valid && instr_ready;
    // An unacked request at redirect must still complete; its word is then dropped.
    state_n = redirect ? ((imem_req && !imem_ack) ? DISCARD : FETCH)
            : (state == FETCH && push && !pop && count == DEPTH - 1'b1) ? HOLD
            : ((state == HOLD && pop) || (state == DISCARD && imem_ack)) ? FETCH
            : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      fpc <= RESET_PC;
      stale <= '0;
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (state != DISCARD) stale <= fpc;
      if (redirect) begin
        fpc <= redirect_pc & 32'hFFFF_FFFC;
        wr <= '0;
        rd <= '0;
        count <= '0;
      end else begin
        if (push) fpc <= fpc + 32'd4;
        if (push) wr <= wr + 1'b1;
        if (pop) rd <= rd + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr] <= fpc;
      mem_ins[wr] <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table plus scoreboard model for the fetch stage.
module tb_instruction_fetch;
  logic clk, reset, imem_req, imem_ack, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, instr_pc4;
  logic req5, valid5;
  logic [31:0] addr5, rdata5, ins5, pc5, pc45;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic pend;
  logic [31:0] stale_e, exp_fpc;

  typedef struct {
    logic rs, rdy, ak, req;
    logic [31:0] addr;
    logic v;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[15];

  assign imem_rdata = ~imem_addr;
  assign rdata5 = ~addr5;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_pc4(instr_pc4), .instr_ready(instr_ready)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut5 (
    .clk(clk), .reset(reset), .imem_req(req5), .imem_addr(addr5),
    .imem_ack(1'b1), .imem_rdata(rdata5), .redirect(1'b0),
    .redirect_pc(32'h0), .instr_valid(valid5), .instr(ins5),
    .instr_pc(pc5), .instr_pc4(pc45), .instr_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of the stage, evaluated mid-cycle before the next edge.
  task automatic model();
    logic exp_req;
    logic [31:0] e;
    if (!reset) begin
      q.delete();
      pend = 1'b0;
      exp_fpc = 32'h0;
    end else begin
      exp_req = pend || q.size() < 4;
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, pend ? stale_e : exp_fpc);
      chk("instr_valid", instr_valid, q.size() != 0 && !redirect);
      if (instr_valid && instr_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got pc %h expected no instruction", instr_pc);
        end else begin
          e = q.pop_front();
          chk("instr", instr, ~e);
          chk("instr_pc", instr_pc, e);
          chk("instr_pc4", instr_pc4, e + 32'd4);
        end
      end
      if (redirect) begin
        if (exp_req && !imem_ack && !pend) begin
          pend = 1'b1;
          stale_e = exp_fpc;
        end else if (exp_req && imem_ack) pend = 1'b0;
        q.delete();
        exp_fpc = {redirect_pc[31:2], 2'b00};
      end else if (exp_req && imem_ack) begin
        if (pend) pend = 1'b0;
        else begin
          q.push_back(exp_fpc);
          exp_fpc = exp_fpc + 32'd4;
        end
      end
    end
  endtask

  task automatic cyc(input logic rs, input logic rdy, input logic ak, input logic rd, input logic [31:0] rp);
    reset = rs;
    instr_ready = rdy;
    imem_ack = ak;
    redirect = rd;
    redirect_pc = rp;
    @(negedge clk);
    model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; instr_ready = 1'b1; imem_ack = 1'b0; redirect = 1'b0; redirect_pc = '0;
    pend = 1'b0; stale_e = '0; exp_fpc = '0;
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h8};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h4};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h4};
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rs;
      instr_ready = tbl[i].rdy;
      imem_ack = tbl[i].ak;
      redirect = 1'b0;
      redirect_pc = '0;
      @(negedge clk);
      chk($sformatf("t%0d_req", i), imem_req, tbl[i].req);
      if (tbl[i].req || !tbl[i].rs) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), instr_valid, tbl[i].v);
      chk($sformatf("t%0d_pc", i), instr_pc, tbl[i].v ? tbl[i].pc : 32'h0);
      chk($sformatf("t%0d_pc4", i), instr_pc4, tbl[i].v ? tbl[i].pc + 32'd4 : 32'h0);
      chk($sformatf("t%0d_instr", i), instr, tbl[i].v ? ~tbl[i].pc : 32'h0);
      model();
      @(posedge clk);
      #1;
    end
    // Redirect during a wait-stated fetch: stale word must be dropped.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    // Redirect coinciding with an ack, unaligned target.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h203);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    // Wrap of the fetch PC from a high reset address.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("w_req0", req5, 1'b1);
    chk("w_addr0", addr5, 32'hFFFF_FFF8);
    chk("w_valid0", valid5, 1'b0);
    @(negedge clk);
    chk("w_addr1", addr5, 32'hFFFF_FFFC);
    chk("w_pc1", pc5, 32'hFFFF_FFF8);
    chk("w_pc4_1", pc45, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("w_addr2", addr5, 32'h0);
    chk("w_pc2", pc5, 32'hFFFF_FFFC);
    chk("w_pc4_2", pc45, 32'h0);
    chk("w_instr2", ins5, 32'h0000_0003);
    @(posedge clk);
    #1;
    // Asynchronous reset mid-wait with three buffered entries.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("ar_valid_pre", instr_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk("ar_valid", instr_valid, 1'b0);
    chk("ar_req", imem_req, 1'b0);
    chk("ar_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
